// File: rtl/parser_ingress_arbiter.sv
// parser_ingress_arbiter
// Round-robin packet scheduler in front of the packet parser. It grants one
// whole packet at a time from NUM_REQ word streams and drives the parser's
// single bus with packet-atomic framing. After every packet end or abort it
// forces an idle gap. It discards orphan words (valid without sop outside a
// packet). It aborts a packet whose source stalls or restarts mid-packet.
//
// Ports
//   CLK                clock
//   reset              synchronous active-low reset
//   req_valid_i        per-requester word valid
//   req_data_i         per-requester word, requester r at slice r, byte 0 in MSBs
//   req_sop_i          word is first of packet
//   req_eop_i          word is last of packet
//   req_bcnt_i         valid bytes in eop word, 0 means BUS_W_B
//   req_ready_o        word accepted on a rising edge where valid&ready
//   bus_o              word to parser
//   start_of_packet_o  first word of packet on bus_o
//   word_valid_o       bus_o carries a packet word
//   eop_o              last word of packet (normal or abort)
//   abort_o            packet truncated, coincident with eop_o
//   src_id_o           granted requester
//   busy_o             FSM not in IDLE
//   drop_cnt_o         saturating count of discarded orphan words
//   dbg_state_o        current FSM state (0 IDLE, 1 XFER, 2 GAP)
//
// Handshake: a word moves from requester r on a rising CLK edge where both
// req_valid_i[r] and req_ready_o[r] are high. While valid is high and ready
// is low, the requester holds data/sop/eop/bcnt stable. The output side has
// no backpressure.

module parser_ingress_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BUS_W_B     = 4,
  parameter int IDLE_GAP    = 1,
  parameter int STALL_LIMIT = 16,
  localparam int BUS_W   = BUS_W_B * 8,
  localparam int BCNT_W  = (BUS_W_B > 1) ? $clog2(BUS_W_B) : 1,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int STALL_W = $clog2(STALL_LIMIT + 1)
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*BUS_W-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]        req_sop_i,
  input  logic [NUM_REQ-1:0]        req_eop_i,
  input  logic [NUM_REQ*BCNT_W-1:0] req_bcnt_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [BUS_W-1:0]          bus_o,
  output logic                      start_of_packet_o,
  output logic                      word_valid_o,
  output logic                      eop_o,
  output logic                      abort_o,
  output logic [SRC_W-1:0]          src_id_o,
  output logic                      busy_o,
  output logic [15:0]               drop_cnt_o,
  output logic [1:0]                dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_q;
  logic [SRC_W-1:0]    rr_ptr_q, grant_q;
  logic [STALL_W-1:0]  stall_cnt_q;
  logic [3:0]          gap_cnt_q;
  logic                first_q;
  logic [BUS_W-1:0]    bus_q;
  logic                sop_q, valid_q, eop_q, abort_q;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  // Granted lane views
  logic              g_valid, g_sop, g_eop;
  logic [BUS_W-1:0]  g_data, masked;
  logic [BCNT_W-1:0] g_bcnt;

  assign g_valid = req_valid_i[grant_q];
  assign g_sop   = req_sop_i[grant_q];
  assign g_eop   = req_eop_i[grant_q];
  assign g_data  = req_data_i[int'(grant_q)*BUS_W +: BUS_W];
  assign g_bcnt  = req_bcnt_i[int'(grant_q)*BCNT_W +: BCNT_W];

  logic [NUM_REQ-1:0] cand, orphan;
  assign cand   = req_valid_i & req_sop_i;
  assign orphan = req_valid_i & ~req_sop_i;

  // Round-robin search: first sop candidate at or after rr_ptr, with wrap.
  logic             arb_found;
  logic [SRC_W-1:0] arb_idx;
  int               arb_scan;
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr_q;
    arb_scan  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_scan = int'(rr_ptr_q) + i;
      if (arb_scan >= NUM_REQ) arb_scan = arb_scan - NUM_REQ;
      if (!arb_found && cand[arb_scan]) begin
        arb_found = 1'b1;
        arb_idx   = SRC_W'(arb_scan);
      end
    end
  end

  logic in_xfer, perr, acc, stall_hit, abort_now, pkt_end;
  // A sop on a non-first word means the source restarted: refuse the word
  // so it can be arbitrated later as a fresh packet.
  assign in_xfer   = (state_q == ST_XFER);
  assign perr      = in_xfer & g_valid & g_sop & ~first_q;
  assign acc       = in_xfer & g_valid & ~perr;
  assign stall_hit = in_xfer & ~g_valid &
                     (stall_cnt_q == STALL_W'(STALL_LIMIT - 1));
  assign abort_now = perr | stall_hit;
  assign pkt_end   = (acc & g_eop) | abort_now;

  always_comb begin
    req_ready_o = '0;
    if (reset) begin
      if (in_xfer) begin
        if (!perr) req_ready_o[grant_q] = 1'b1;
      end else begin
        req_ready_o = orphan;
      end
    end
  end

  // Zero bytes past bcnt in the eop word (byte 0 sits in the MSBs).
  always_comb begin
    masked = g_data;
    if (g_eop && (g_bcnt != '0)) begin
      for (int b = 0; b < BUS_W_B; b++) begin
        if (b >= int'(g_bcnt)) masked[BUS_W-1-8*b -: 8] = 8'h00;
      end
    end
  end

  // Orphans from several requesters in one cycle each count once.
  logic [3:0]  drop_inc;
  logic [16:0] drop_sum;
  always_comb begin
    drop_inc = '0;
    for (int r = 0; r < NUM_REQ; r++) drop_inc = drop_inc + {3'b000, orphan[r]};
    drop_sum   = {1'b0, drop_cnt_q} + {13'd0, drop_inc};
    drop_cnt_d = drop_cnt_q;
    if (!in_xfer) drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      stall_cnt_q <= '0;
      gap_cnt_q   <= '0;
      first_q     <= 1'b0;
      bus_q       <= '0;
      sop_q       <= 1'b0;
      valid_q     <= 1'b0;
      eop_q       <= 1'b0;
      abort_q     <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      sop_q      <= 1'b0;
      valid_q    <= 1'b0;
      eop_q      <= 1'b0;
      abort_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            grant_q     <= arb_idx;
            first_q     <= 1'b1;
            stall_cnt_q <= '0;
            state_q     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (acc) begin
            bus_q       <= masked;
            valid_q     <= 1'b1;
            sop_q       <= first_q;
            eop_q       <= g_eop;
            first_q     <= 1'b0;
            stall_cnt_q <= '0;
          end else if (!perr) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
          if (abort_now) begin
            bus_q   <= '0;
            valid_q <= 1'b1;
            eop_q   <= 1'b1;
            abort_q <= 1'b1;
          end
          if (pkt_end) begin
            rr_ptr_q <= (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
            if (IDLE_GAP == 0) begin
              state_q <= ST_IDLE;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= 4'(IDLE_GAP);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q <= 4'd1) state_q <= ST_IDLE;
          else                   gap_cnt_q <= gap_cnt_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_o             = bus_q;
  assign start_of_packet_o = sop_q;
  assign word_valid_o      = valid_q;
  assign eop_o             = eop_q;
  assign abort_o           = abort_q;
  assign src_id_o          = grant_q;
  assign busy_o            = (state_q != ST_IDLE);
  assign drop_cnt_o        = drop_cnt_q;
  assign dbg_state_o       = state_q;

endmodule

// File: doc/parser_ingress_arbiter.md
Name: parser_ingress_arbiter

Overview:
Round-robin packet scheduler in front of the PacketParserN* datapath. It takes NUM_REQ independent word streams, grants one whole packet at a time, and drives the parser's single bus/start-of-packet input with packet-atomic framing. It inserts a programmable idle gap between packets, discards orphan words, and aborts packets whose source stalls. It tags each packet with its source id for downstream phs_o correlation.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BUS_W_B, 4, bus width in bytes (matches `BUS_WIDTH_B)
IDLE_GAP, 1, idle cycles forced after every packet end/abort (0..15)
STALL_LIMIT, 16, consecutive mid-packet empty cycles before abort (>=1)

Ports:
CLK  in  1  clock
reset  in  1  synchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester word valid
req_data_i  in  NUM_REQ*BUS_W_B*8  per-requester word; requester r at slice r; byte 0 of the word in MSBs
req_sop_i  in  NUM_REQ  word is first of packet
req_eop_i  in  NUM_REQ  word is last of packet
req_bcnt_i  in  NUM_REQ*$clog2(BUS_W_B)  valid bytes in eop word; 0 means BUS_W_B
req_ready_o  out  NUM_REQ  word accepted this cycle when valid&ready
bus_o  out  BUS_W_B*8  word to parser
start_of_packet_o  out  1  first word of packet on bus_o
word_valid_o  out  1  bus_o carries a packet word
eop_o  out  1  last word of packet (normal or abort)
abort_o  out  1  packet was truncated (stall or protocol error), coincident with eop_o
src_id_o  out  $clog2(NUM_REQ)  granted requester, stable while word_valid_o
busy_o  out  1  state != IDLE
drop_cnt_o  out  16  saturating count of discarded orphan words

Behaviour:
- Reset (reset==0 at posedge CLK): state=IDLE, rr_ptr=0, stall_cnt=0, gap_cnt=0. All outputs 0: bus_o, start_of_packet_o, word_valid_o, eop_o, abort_o, src_id_o, busy_o, req_ready_o, drop_cnt_o. Reset mid-packet discards the packet silently; no eop is emitted.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - Candidates are r with req_valid_i[r]&req_sop_i[r]. Grant the first candidate at or after rr_ptr, searching upward with wrap.
  - The grant is registered; next state XFER. No word is accepted in the grant cycle.
  - Any requester with valid&~sop sees ready=1 in IDLE and GAP. The word is discarded and drop_cnt increments, saturating at 16'hFFFF.
  - Simultaneous orphans from k requesters increment the count by k.
- XFER:
  - req_ready_o[grant]=1 unless a protocol error is detected this cycle. All other ready=0.
  - Accepted word appears on bus_o one cycle later with word_valid_o=1. start_of_packet_o is set on the first word only; eop_o follows the accepted eop.
  - Bytes beyond bcnt in the eop word are zeroed on bus_o.
  - Cycles without an accepted word: word_valid_o=0, start_of_packet_o=0, bus_o holds its last value, stall_cnt increments. Any accepted word clears stall_cnt.
  - eop accepted: next state GAP; rr_ptr=(grant+1) mod NUM_REQ.
  - Single-word packet (sop&eop): start_of_packet_o and eop_o are high on the same cycle.
  - stall_cnt reaches STALL_LIMIT: next cycle output word_valid_o=1, eop_o=1, abort_o=1, bus_o=0; then GAP with rr_ptr advanced. The remainder of that packet later arrives without sop and is dropped as orphans.
  - Granted requester presents sop on a non-first word (protocol error): ready=0 that cycle and the word is not consumed. Emit an abort word as above, then GAP. The new sop word is arbitrated normally later.
- GAP:
  - Hold all word outputs low for IDLE_GAP cycles, then IDLE.
  - IDLE_GAP=0: go from XFER directly to IDLE.
- Pipeline and throughput:
  - Latency from the first accepted word to bus_o is 1 cycle. The parser has no backpressure; this block never stalls output once a word is accepted.
  - Minimum inter-packet spacing is 1 arbitration cycle + IDLE_GAP.
- busy_o is high in XFER and GAP.

Test Plan:
- Single requester 0: 64-byte packet, BUS_W_B=4, bcnt=0 on the last word -> grant after 1 cycle; 16 words on bus_o; start_of_packet_o on word 0, eop_o on word 15; src_id_o=0; busy_o drops after IDLE_GAP+1 cycles.
- Requesters 0..3 all hold sop continuously with 3-word packets -> grants in order 0,1,2,3,0. Each packet is contiguous with no interleaving; exactly 1+IDLE_GAP idle cycles between packets.
- Packet of 13 bytes (last word bcnt=1, data 0xAABBCCDD) -> final bus_o=0xAA000000, eop_o=1, abort_o=0.
- Requester 2 goes idle for 16 cycles after word 2 (STALL_LIMIT=16) -> abort word (eop_o=1, abort_o=1, bus_o=0). The 3 trailing words it then sends are dropped; drop_cnt_o=3.
- Requester 1 sends sop, word, then sop again without eop -> abort after 2 words. The second sop word is not consumed and is granted as a new packet after the gap.
- reset=0 asserted for 1 cycle mid-packet -> all outputs 0 on the next cycle, no eop emitted; rr_ptr=0, so requester 0 wins the next simultaneous request.
